// File: rtl/fft_frame_serializer.sv
// FFT frame serializer: captures 512-point frames delivered as 32 beats of
// 16 parallel complex lanes into a ping-pong buffer and replays each frame
// as a one-sample-per-cycle valid/ready stream, optionally in bit-reversed
// address order to restore natural frequency order.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   din_valid         one beat of LANES samples on din_i/din_q
//   din_i, din_q      lane j in din_*[j], lane 0 is the lowest address
//   dout_valid/ready  serial sample handshake
//   dout_i, dout_q    serial sample
//   dout_index        output sequence index 0..N-1
//   dout_sof/eof      high with index 0 / index N-1
//   overflow          sticky, a frame was dropped for lack of a free bank
//   busy              a bank is full or a frame is partially written
module fft_frame_serializer #(
  parameter int LANES  = 16,
  parameter int BEATS  = 32,
  parameter int DW     = 12,
  parameter bit BITREV = 1'b0,
  localparam int N     = LANES * BEATS,
  localparam int AW    = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_valid,
  input  logic [LANES-1:0][DW-1:0] din_i,
  input  logic [LANES-1:0][DW-1:0] din_q,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [DW-1:0]            dout_i,
  output logic [DW-1:0]            dout_q,
  output logic [AW-1:0]            dout_index,
  output logic                     dout_sof,
  output logic                     dout_eof,
  output logic                     overflow,
  output logic                     busy
);

  localparam int LW = $clog2(LANES);
  localparam int BW = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_t;

  logic [DW-1:0] mem_i [2][N];
  logic [DW-1:0] mem_q [2][N];

  logic [BW-1:0] wr_beat;
  logic          wr_bank;
  logic          drop;
  logic [1:0]    bank_full;

  state_t        state;
  logic          rd_bank;
  logic [AW-1:0] rd_idx;

  logic          hs;
  logic          rd_last;
  logic          rd_clr;
  logic [1:0]    clr_vec;
  logic [1:0]    set_vec;
  logic [1:0]    full_nxt;
  logic          first;
  logic          last_beat;
  logic          drop_now;
  logic          store;
  logic          ld;
  logic          ld_bank;
  logic [AW-1:0] ld_idx;

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] k);
    addr_of = k;
    if (BITREV) begin
      for (int b = 0; b < AW; b++) addr_of[b] = k[AW-1-b];
    end
  endfunction

  // Bank release seen by the writer is the next-state value, so a frame
  // starting on the same edge a bank drains is still accepted.
  always_comb begin
    hs      = dout_valid & dout_ready;
    rd_last = rd_idx == AW'(N - 1);
    rd_clr  = (state == STREAM) & hs & rd_last;
    clr_vec = '0;
    if (rd_clr) clr_vec[rd_bank] = 1'b1;
    full_nxt = bank_full & ~clr_vec;
  end

  always_comb begin
    first     = wr_beat == '0;
    last_beat = wr_beat == BW'(BEATS - 1);
    drop_now  = first ? full_nxt[wr_bank] : drop;
    store     = din_valid & ~drop_now;
    set_vec   = '0;
    if (store & last_beat) set_vec[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_beat   <= '0;
      wr_bank   <= 1'b0;
      drop      <= 1'b0;
      overflow  <= 1'b0;
      bank_full <= '0;
    end else begin
      bank_full <= full_nxt | set_vec;
      if (din_valid) begin
        wr_beat <= last_beat ? '0 : wr_beat + 1'b1;
        if (first) begin
          drop <= full_nxt[wr_bank];
          if (full_nxt[wr_bank]) overflow <= 1'b1;
        end
        if (last_beat) begin
          drop <= 1'b0;
          if (!drop_now) wr_bank <= ~wr_bank;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      for (int j = 0; j < LANES; j++) begin
        mem_i[wr_bank][{wr_beat, LW'(j)}] <= din_i[j];
        mem_q[wr_bank][{wr_beat, LW'(j)}] <= din_q[j];
      end
    end
  end

  // Selects which sample, if any, is registered onto the output this edge;
  // the last handshake of a frame chains straight into the other bank.
  always_comb begin
    ld      = 1'b0;
    ld_bank = rd_bank;
    ld_idx  = rd_idx;
    unique case (state)
      LOAD: ld = 1'b1;
      STREAM: begin
        if (hs) begin
          if (!rd_last) begin
            ld     = 1'b1;
            ld_idx = rd_idx + 1'b1;
          end else if (bank_full[~rd_bank]) begin
            ld      = 1'b1;
            ld_bank = ~rd_bank;
            ld_idx  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      dout_valid <= 1'b0;
      dout_i     <= '0;
      dout_q     <= '0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bank_full[rd_bank]) state <= LOAD;
        LOAD: state <= STREAM;
        STREAM: begin
          if (rd_clr && !ld) begin
            state      <= IDLE;
            rd_bank    <= ~rd_bank;
            rd_idx     <= '0;
            dout_valid <= 1'b0;
            dout_i     <= '0;
            dout_q     <= '0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (ld) begin
        state      <= STREAM;
        rd_bank    <= ld_bank;
        rd_idx     <= ld_idx;
        dout_valid <= 1'b1;
        dout_i     <= mem_i[ld_bank][addr_of(ld_idx)];
        dout_q     <= mem_q[ld_bank][addr_of(ld_idx)];
        dout_sof   <= ld_idx == '0;
        dout_eof   <= ld_idx == AW'(N - 1);
      end
    end
  end

  assign dout_index = rd_idx;
  assign busy       = (|bank_full) | (wr_beat != '0);

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Scoreboard bench for fft_frame_serializer: one natural-order and one
// bit-reversed instance share stimulus; a monitor checks each output stream.
module tb_fft_frame_serializer;
  localparam int LANES = 16;
  localparam int BEATS = 32;
  localparam int DW    = 12;
  localparam int N     = LANES * BEATS;

  typedef struct packed {
    logic [11:0] i;
    logic [11:0] q;
    logic [8:0]  idx;
    logic        sof;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic dout_ready = 1'b0;
  logic [LANES-1:0][DW-1:0] din_i = '0;
  logic [LANES-1:0][DW-1:0] din_q = '0;

  logic v0, v1, s0, s1, e0, e1, ov0, ov1, b0, b1;
  logic [11:0] i0, i1, q0, q1;
  logic [8:0] x0, x1;

  int total = 0;
  int passed = 0;
  int rmode = 0;
  logic [11:0] fi[N];
  logic [11:0] fq[N];
  exp_t sb[2][$];
  logic pv[2];
  logic pr[2];
  exp_t ph[2];

  fft_frame_serializer #(
    .LANES(LANES), .BEATS(BEATS), .DW(DW), .BITREV(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .din_valid(din_valid),
    .din_i(din_i), .din_q(din_q),
    .dout_valid(v0), .dout_ready(dout_ready),
    .dout_i(i0), .dout_q(q0), .dout_index(x0),
    .dout_sof(s0), .dout_eof(e0),
    .overflow(ov0), .busy(b0)
  );

  fft_frame_serializer #(
    .LANES(LANES), .BEATS(BEATS), .DW(DW), .BITREV(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .din_valid(din_valid),
    .din_i(din_i), .din_q(din_q),
    .dout_valid(v1), .dout_ready(dout_ready),
    .dout_i(i1), .dout_q(q1), .dout_index(x1),
    .dout_sof(s1), .dout_eof(e1),
    .overflow(ov1), .busy(b1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d",
             passed, total);
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input string info);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: %s", name, info);
  endtask

  function automatic int bitrev9(input int m);
    int r = 0;
    for (int b = 0; b < 9; b++) if (((m >> b) & 1) == 1) r |= 1 << (8 - b);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) begin
      fi[k] = 12'(k - 256);
      fq[k] = 12'(255 - k);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) begin
      fi[k] = 12'($urandom);
      fq[k] = 12'($urandom);
    end
  endtask

  task automatic push_exp();
    exp_t x;
    int a;
    for (int m = 0; m < N; m++) begin
      x.idx = 9'(m);
      x.sof = (m == 0);
      x.eof = (m == N - 1);
      x.i = fi[m];
      x.q = fq[m];
      sb[0].push_back(x);
      a = bitrev9(m);
      x.i = fi[a];
      x.q = fq[a];
      sb[1].push_back(x);
    end
  endtask

  task automatic drive_frame(input int gap_at, input int gap_len,
                             input bit stored);
    if (stored) push_exp();
    for (int b = 0; b < BEATS; b++) begin
      for (int j = 0; j < LANES; j++) begin
        din_i[j] = fi[b*LANES+j];
        din_q[j] = fq[b*LANES+j];
      end
      din_valid = 1'b1;
      step();
      if (b == gap_at) begin
        din_valid = 1'b0;
        for (int j = 0; j < LANES; j++) begin
          din_i[j] = 12'($urandom);
          din_q[j] = 12'($urandom);
        end
        repeat (gap_len) step();
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic check_latency(input string tag);
    @(negedge clk);
    @(negedge clk);
    check(!v0 && !v1, {tag, "_early"},
          $sformatf("valid %0d/%0d one edge after capture, want 0", v0, v1));
    @(negedge clk);
    check(v0 && s0 && v1 && s1, {tag, "_latency"},
          $sformatf("valid %0d/%0d sof %0d/%0d two edges after capture, want 1",
                    v0, v1, s0, s1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0 || v0 || v1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(n < 5000, {tag, "_drain"},
          $sformatf("%0d/%0d samples never arrived", sb[0].size(), sb[1].size()));
    check(!b0 && !b1 && !v0 && !v1, {tag, "_idle"},
          $sformatf("busy %0d/%0d valid %0d/%0d after drain, want 0",
                    b0, b1, v0, v1));
  endtask

  task automatic wait_eof(input string tag);
    int n = 0;
    bit found = 1'b0;
    while (!found && n < 3000) begin
      @(negedge clk);
      n++;
      if (v0 && dout_ready && e0) found = 1'b1;
    end
    check(found, tag, $sformatf("no eof handshake within %0d cycles", n));
  endtask

  task automatic check_zero(input string tag);
    check(!v0 && i0 == 0 && q0 == 0 && x0 == 0 && !s0 && !e0 && !ov0 && !b0,
          {tag, "0"},
          $sformatf("v=%0d i=%h q=%h idx=%0d sof=%0d eof=%0d ovf=%0d busy=%0d want all 0",
                    v0, i0, q0, x0, s0, e0, ov0, b0));
    check(!v1 && i1 == 0 && q1 == 0 && x1 == 0 && !s1 && !e1 && !ov1 && !b1,
          {tag, "1"},
          $sformatf("v=%0d i=%h q=%h idx=%0d sof=%0d eof=%0d ovf=%0d busy=%0d want all 0",
                    v1, i1, q1, x1, s1, e1, ov1, b1));
  endtask

  task automatic mon(input int k, input logic v, input logic [11:0] di,
                     input logic [11:0] dq, input logic [8:0] dx,
                     input logic s, input logic e);
    exp_t cur;
    exp_t x;
    cur = {di, dq, dx, s, e};
    if (rst) begin
      pv[k] = 1'b0;
      pr[k] = 1'b0;
      return;
    end
    if (pv[k] && !pr[k])
      check(v && cur == ph[k], $sformatf("hold%0d", k),
            $sformatf("got v=%0d %h, want held %h", v, cur, ph[k]));
    if (v && dout_ready) begin
      check(sb[k].size() != 0, $sformatf("extra%0d", k),
            $sformatf("unexpected sample idx=%0d, want none", dx));
      if (sb[k].size() != 0) begin
        x = sb[k].pop_front();
        check(cur == x, $sformatf("sample%0d", k),
              $sformatf("got i=%h q=%h idx=%0d sof=%0d eof=%0d want i=%h q=%h idx=%0d sof=%0d eof=%0d",
                        di, dq, dx, s, e, x.i, x.q, x.idx, x.sof, x.eof));
      end
    end
    pv[k] = v;
    pr[k] = dout_ready;
    ph[k] = cur;
  endtask

  always @(negedge clk) begin
    mon(0, v0, i0, q0, x0, s0, e0);
    mon(1, v1, i1, q1, x1, s1, e1);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 2) dout_ready = 1'($urandom_range(0, 1));
      else dout_ready = (rmode == 1);
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    rmode = 1;
    step();
    fill_ramp();
    drive_frame(-1, 0, 1'b1);
    check_latency("single");
    check(!ov0 && !ov1, "single_ovf",
          $sformatf("overflow %0d/%0d, want 0", ov0, ov1));
    drain("single");

    rmode = 2;
    step();
    fill_rand();
    drive_frame(-1, 0, 1'b1);
    drain("backpressure");

    rmode = 1;
    step();
    step();
    fill_rand();
    drive_frame(10, 3, 1'b1);
    check_latency("gapped");
    drain("gapped");

    step();
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      drive_frame(-1, 0, 1'b1);
      repeat (N - BEATS) step();
    end
    check(!ov0 && !ov1, "sustained_ovf",
          $sformatf("overflow %0d/%0d, want 0", ov0, ov1));
    drain("sustained");

    rmode = 0;
    step();
    step();
    fill_rand();
    drive_frame(-1, 0, 1'b1);
    fill_rand();
    drive_frame(-1, 0, 1'b1);
    fill_rand();
    drive_frame(-1, 0, 1'b0);
    @(negedge clk);
    check(ov0 && ov1, "ovf_set",
          $sformatf("overflow %0d/%0d, want 1", ov0, ov1));
    check(b0 && b1 && v0 && v1 && s0 && s1, "ovf_pending",
          $sformatf("busy %0d/%0d valid %0d/%0d sof %0d/%0d, want 1",
                    b0, b1, v0, v1, s0, s1));
    rmode = 1;
    wait_eof("ovf_eof1");
    @(negedge clk);
    check(v0 && s0 && x0 == 0 && v1 && s1 && x1 == 0, "ovf_contig",
          $sformatf("after eof valid %0d/%0d sof %0d/%0d idx %0d/%0d, want 1/1 1/1 0/0",
                    v0, v1, s0, s1, x0, x1));
    wait_eof("ovf_eof2");
    @(negedge clk);
    check(!v0 && !v1, "ovf_end",
          $sformatf("valid %0d/%0d after second frame, want 0", v0, v1));
    drain("ovf");

    rmode = 1;
    step();
    fill_rand();
    drive_frame(-1, 0, 1'b1);
    n = 0;
    while (!(v0 && x0 == 9'd200) && n < 2000) begin
      step();
      n++;
    end
    check(n < 2000, "rst_reach",
          $sformatf("index 200 not presented, idx=%0d", x0));
    rst = 1'b1;
    @(posedge clk);
    sb[0].delete();
    sb[1].delete();
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    step();
    fill_ramp();
    drive_frame(-1, 0, 1'b1);
    check_latency("post_reset");
    drain("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
